threshold_dither: RTL and testbench

- Producer of the 1-bit dithered pixel stream consumed by the threshold feedback loop.
- Converts an 8-bit grayscale pixel stream into 1-bit pixels by comparing against a per-frame threshold, with horizontal (same-line) error diffusion.
- Sits between the grayscale conversion stage and the GIF encoder / threshold feedback logic.
- Takes the threshold each frame and reports frame boundaries.

---
 rtl/threshold_dither.sv | 125 ++++++++++++
 tb/tb_threshold_dither.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_dither.sv
// threshold_dither
//   Turns an 8-bit grayscale raster stream into a 1-bit stream. Each pixel is
//   compared against a threshold that is latched once per frame. Optionally,
//   half of the quantisation error is carried to the next pixel on the same line.
//
// Ports
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   pixel_in, pixel_valid_in  grayscale pixel in raster order, one per valid cycle
//   threshold_in              threshold for the next frame, latched at pixel (0,0)
//   diffuse_en_in             error diffusion enable, latched with threshold_in
//   dithered_pixel            1-bit result (1 = white), one cycle after input
//   dithered_valid            registered copy of pixel_valid_in
//   hcount_out, vcount_out    column/row of the pixel on dithered_pixel
//   frame_done                pulse alongside the last pixel of a frame
//   active_threshold          threshold in use for the current frame
module threshold_dither #(
    parameter int unsigned H_ACTIVE        = 320,
    parameter int unsigned V_ACTIVE        = 240,
    parameter int unsigned RESET_THRESHOLD = 60
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid_in,
    input  logic [7:0] threshold_in,
    input  logic       diffuse_en_in,
    output logic       dithered_pixel,
    output logic       dithered_valid,
    output logic [8:0] hcount_out,
    output logic [7:0] vcount_out,
    output logic       frame_done,
    output logic [7:0] active_threshold
);

    logic [8:0]        r_col;
    logic [7:0]        r_row;
    logic signed [8:0] r_carry;
    logic [7:0]        r_thresh;
    logic              r_diff;
    logic              r_pixel;
    logic              r_valid;
    logic [8:0]        r_hcount;
    logic [7:0]        r_vcount;
    logic              r_frame_done;

    logic              w_first;
    logic              w_col_last;
    logic              w_row_last;
    logic [7:0]        w_thresh;
    logic              w_diff;
    logic signed [8:0] w_carry_in;
    logic signed [9:0] w_sum;
    logic              w_out;
    logic signed [9:0] w_err;
    logic signed [9:0] w_shift;
    logic signed [8:0] w_carry_sat;

    assign w_first    = (r_col == '0) && (r_row == '0);
    assign w_col_last = (r_col == 9'(H_ACTIVE - 1));
    assign w_row_last = (r_row == 8'(V_ACTIVE - 1));

    // The first pixel of a frame already uses the values being latched.
    assign w_thresh   = w_first ? threshold_in  : r_thresh;
    assign w_diff     = w_first ? diffuse_en_in : r_diff;
    assign w_carry_in = w_diff ? r_carry : '0;

    always_comb begin
        w_sum   = $signed({2'b00, pixel_in}) + $signed({w_carry_in[8], w_carry_in});
        w_out   = (w_sum >= $signed({2'b00, w_thresh}));
        w_err   = w_sum - (w_out ? 10'sd255 : 10'sd0);
        w_shift = w_err >>> 1;
        if (w_shift > 10'sd127) begin
            w_carry_sat = 9'sd127;
        end else if (w_shift < -10'sd128) begin
            w_carry_sat = -9'sd128;
        end else begin
            w_carry_sat = w_shift[8:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_col        <= '0;
            r_row        <= '0;
            r_carry      <= '0;
            r_thresh     <= 8'(RESET_THRESHOLD);
            r_diff       <= 1'b1;
            r_pixel      <= 1'b0;
            r_valid      <= 1'b0;
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= pixel_valid_in;
            r_frame_done <= pixel_valid_in && w_col_last && w_row_last;
            if (pixel_valid_in) begin
                r_pixel  <= w_out;
                r_hcount <= r_col;
                r_vcount <= r_row;
                r_thresh <= w_thresh;
                r_diff   <= w_diff;
                // No error crosses a line boundary.
                if (w_col_last || !w_diff) begin
                    r_carry <= '0;
                end else begin
                    r_carry <= w_carry_sat;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 8'd1;
                end else begin
                    r_col <= r_col + 9'd1;
                end
            end
        end
    end

    assign dithered_pixel   = r_pixel;
    assign dithered_valid   = r_valid;
    assign hcount_out       = r_hcount;
    assign vcount_out       = r_vcount;
    assign frame_done       = r_frame_done;
    assign active_threshold = r_thresh;

endmodule

// File: tb/tb_threshold_dither.sv
module tb_threshold_dither;

    localparam int H = 20;
    localparam int V = 6;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [7:0] pixel_in;
    logic       pixel_valid_in;
    logic [7:0] threshold_in;
    logic       diffuse_en_in;
    logic       dithered_pixel;
    logic       dithered_valid;
    logic [8:0] hcount_out;
    logic [7:0] vcount_out;
    logic       frame_done;
    logic [7:0] active_threshold;

    always #5 clk_in = ~clk_in;

    threshold_dither #(
        .H_ACTIVE        (H),
        .V_ACTIVE        (V),
        .RESET_THRESHOLD (60)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .pixel_in         (pixel_in),
        .pixel_valid_in   (pixel_valid_in),
        .threshold_in     (threshold_in),
        .diffuse_en_in    (diffuse_en_in),
        .dithered_pixel   (dithered_pixel),
        .dithered_valid   (dithered_valid),
        .hcount_out       (hcount_out),
        .vcount_out       (vcount_out),
        .frame_done       (frame_done),
        .active_threshold (active_threshold)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the dither, kept as plain integers.
    int m_col, m_row, m_carry, m_thr, m_diff;
    int e_out, e_h, e_v, e_fd, e_thr;

    task automatic model_reset();
        m_col = 0; m_row = 0; m_carry = 0; m_thr = 60; m_diff = 1;
    endtask

    task automatic model_step(input int pix);
        int c, sum, err, nc;
        if (m_col == 0 && m_row == 0) begin
            m_thr  = int'(threshold_in);
            m_diff = int'(diffuse_en_in);
        end
        c     = m_diff ? m_carry : 0;
        sum   = pix + c;
        e_out = (sum >= m_thr) ? 1 : 0;
        err   = sum - (e_out ? 255 : 0);
        nc    = err >>> 1;
        if (nc > 127)  nc = 127;
        if (nc < -128) nc = -128;
        e_h   = m_col;
        e_v   = m_row;
        e_thr = m_thr;
        e_fd  = (m_col == H-1 && m_row == V-1) ? 1 : 0;
        m_col++;
        if (m_col == H) begin
            m_col = 0;
            nc    = 0;
            m_row++;
            if (m_row == V) m_row = 0;
        end
        m_carry = m_diff ? nc : 0;
    endtask

    task automatic do_reset();
        pixel_valid_in = 1'b0;
        rst_n_in       = 1'b0;
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        model_reset();
    endtask

    // Drive one cycle, then check the registered outputs against the model.
    task automatic step(input bit v, input int pix);
        pixel_valid_in = v;
        pixel_in       = pix[7:0];
        if (v) model_step(pix);
        @(posedge clk_in);
        #1;
        chk("valid", int'(dithered_valid), int'(v));
        chk("frame_done", int'(frame_done), v ? e_fd : 0);
        if (v) begin
            chk("pixel", int'(dithered_pixel), e_out);
            chk("hcount", int'(hcount_out), e_h);
            chk("vcount", int'(vcount_out), e_v);
            chk("active_threshold", int'(active_threshold), e_thr);
        end
    endtask

    typedef struct {
        bit rst;
        int pix;
        int thr;
        bit den;
        int e_px;
        int e_h;
        int e_v;
        int e_thr;
    } vec_t;

    function automatic vec_t mk(input bit rst, input int pix, input int thr, input bit den,
                                input int e_px, input int e_h, input int e_v, input int e_thr);
        vec_t r;
        r.rst = rst; r.pix = pix; r.thr = thr; r.den = den;
        r.e_px = e_px; r.e_h = e_h; r.e_v = e_v; r.e_thr = e_thr;
        return r;
    endfunction

    vec_t tbl[$];
    int   ref_out[H*V];
    int   line0[H];

    initial begin
        int cnt_valid, cnt_fd, cnt_one, gaps;

        rst_n_in       = 1'b0;
        pixel_in       = '0;
        pixel_valid_in = 1'b0;
        threshold_in   = 8'd100;
        diffuse_en_in  = 1'b0;
        #12;
        chk("reset_valid", int'(dithered_valid), 0);
        chk("reset_pixel", int'(dithered_pixel), 0);
        chk("reset_hcount", int'(hcount_out), 0);
        chk("reset_vcount", int'(vcount_out), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_threshold", int'(active_threshold), 60);

        // Hand-computed vectors.
        tbl.push_back(mk(1, 127, 128, 0, 0, 0, 0, 128));
        tbl.push_back(mk(0, 128, 128, 0, 1, 1, 0, 128));   // sum == threshold
        tbl.push_back(mk(0,   0, 128, 0, 0, 2, 0, 128));
        tbl.push_back(mk(0, 255, 128, 0, 1, 3, 0, 128));
        tbl.push_back(mk(0, 200, 255, 1, 1, 4, 0, 128));   // mid-frame change ignored
        tbl.push_back(mk(0, 100, 255, 1, 0, 5, 0, 128));
        tbl.push_back(mk(1,   0,   0, 0, 1, 0, 0,   0));   // threshold 0
        tbl.push_back(mk(0, 255,   0, 0, 1, 1, 0,   0));
        tbl.push_back(mk(1, 254, 255, 0, 0, 0, 0, 255));   // threshold 255
        tbl.push_back(mk(0, 255, 255, 0, 1, 1, 0, 255));
        tbl.push_back(mk(1, 100, 128, 1, 0, 0, 0, 128));   // diffusion, carry 0,50,-53,23,61,-47,26,63
        tbl.push_back(mk(0, 100, 128, 1, 1, 1, 0, 128));
        tbl.push_back(mk(0, 100, 128, 1, 0, 2, 0, 128));
        tbl.push_back(mk(0, 100, 128, 1, 0, 3, 0, 128));
        tbl.push_back(mk(0, 100, 128, 1, 1, 4, 0, 128));
        tbl.push_back(mk(0, 100, 128, 1, 0, 5, 0, 128));
        tbl.push_back(mk(0, 100, 128, 1, 0, 6, 0, 128));
        tbl.push_back(mk(0, 100, 128, 1, 1, 7, 0, 128));
        tbl.push_back(mk(1,  64, 128, 1, 0, 0, 0, 128));   // carry 32, then 96+32 == 128
        tbl.push_back(mk(0,  96, 128, 1, 1, 1, 0, 128));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            threshold_in   = tbl[i].thr[7:0];
            diffuse_en_in  = tbl[i].den;
            pixel_in       = tbl[i].pix[7:0];
            pixel_valid_in = 1'b1;
            @(posedge clk_in);
            #1;
            pixel_valid_in = 1'b0;
            chk("tbl_valid", int'(dithered_valid), 1);
            chk("tbl_pixel", int'(dithered_pixel), tbl[i].e_px);
            chk("tbl_hcount", int'(hcount_out), tbl[i].e_h);
            chk("tbl_vcount", int'(vcount_out), tbl[i].e_v);
            chk("tbl_threshold", int'(active_threshold), tbl[i].e_thr);
        end

        // Full frame of 100 against threshold 100, diffusion off.
        threshold_in = 8'd100; diffuse_en_in = 1'b0;
        do_reset();
        cnt_valid = 0; cnt_fd = 0; cnt_one = 0;
        for (int i = 0; i < H*V; i++) begin
            step(1, 100);
            cnt_valid += int'(dithered_valid);
            cnt_fd    += int'(frame_done);
            cnt_one   += int'(dithered_pixel);
            if (i == H*V-1) chk("frame_done_last", int'(frame_done), 1);
        end
        step(0, 0);
        chk("frame_fd_after", int'(frame_done), 0);
        chk("frame_valid_count", cnt_valid, H*V);
        chk("frame_fd_count", cnt_fd, 1);
        chk("frame_ones", cnt_one, H*V);
        step(1, 100);
        chk("frame_wrap_h", int'(hcount_out), 0);
        chk("frame_wrap_v", int'(vcount_out), 0);

        // Ramp 0..255 against 128, diffusion off.
        threshold_in = 8'd128; diffuse_en_in = 1'b0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            step(1, p);
            chk("ramp", int'(dithered_pixel), (p >= 128) ? 1 : 0);
        end

        // Diffusion: line 1 repeats line 0; constant 64 never reaches 128.
        threshold_in = 8'd128; diffuse_en_in = 1'b1;
        do_reset();
        for (int i = 0; i < H; i++) begin
            step(1, 100);
            line0[i] = int'(dithered_pixel);
        end
        for (int i = 0; i < H; i++) begin
            step(1, 100);
            chk("line_repeat", int'(dithered_pixel), line0[i]);
        end
        for (int i = 0; i < H; i++) begin
            step(1, 64);
            chk("const64", int'(dithered_pixel), 0);
        end

        // Threshold change mid-frame takes effect at the next frame.
        threshold_in = 8'd60; diffuse_en_in = 1'b0;
        do_reset();
        for (int i = 0; i < H*V; i++) begin
            if (i == H*V/2) threshold_in = 8'd200;
            step(1, 150);
            chk("thr_old", int'(active_threshold), 60);
        end
        for (int i = 0; i < H*V; i++) begin
            step(1, 150);
            chk("thr_new", int'(active_threshold), 200);
            chk("thr_new_pixel", int'(dithered_pixel), 0);
        end

        // Gapped stream must match the gapless run.
        threshold_in = 8'd110; diffuse_en_in = 1'b1;
        do_reset();
        for (int i = 0; i < H*V; i++) begin
            step(1, (i*37 + 11) % 256);
            ref_out[i] = int'(dithered_pixel);
        end
        do_reset();
        for (int i = 0; i < H*V; i++) begin
            gaps = 0;
            while ($urandom_range(0, 99) < 70 && gaps < 20) begin
                step(0, 0);
                gaps++;
            end
            step(1, (i*37 + 11) % 256);
            chk("gap_pixel", int'(dithered_pixel), ref_out[i]);
            chk("gap_h", int'(hcount_out), i % H);
            chk("gap_v", int'(vcount_out), i / H);
        end

        // Asynchronous reset mid-frame at (15,3).
        threshold_in = 8'd200; diffuse_en_in = 1'b1;
        do_reset();
        for (int i = 0; i <= 3*H + 15; i++) step(1, 150);
        chk("pre_reset_h", int'(hcount_out), 15);
        chk("pre_reset_v", int'(vcount_out), 3);
        pixel_valid_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("async_valid", int'(dithered_valid), 0);
        chk("async_pixel", int'(dithered_pixel), 0);
        chk("async_h", int'(hcount_out), 0);
        chk("async_v", int'(vcount_out), 0);
        chk("async_thr", int'(active_threshold), 60);
        threshold_in = 8'd128;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
        step(1, 100);
        chk("post_reset_h", int'(hcount_out), 0);
        chk("post_reset_v", int'(vcount_out), 0);
        chk("post_reset_thr", int'(active_threshold), 128);
        chk("post_reset_px0", int'(dithered_pixel), 0);
        step(1, 100);
        chk("post_reset_px1", int'(dithered_pixel), 1);
        step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
